// File: rtl/onehz_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : onehz_period_monitor
// Brief    : Checks the 1 Hz timebase in the 50 MHz domain. It measures each
//            rise-to-rise period and flags too-fast, too-slow and stuck ticks.
// Revision : 1.0 - initial release
// ============================================================================
module onehz_period_monitor #(
  parameter int unsigned NOMINAL = 50000000,
  parameter int unsigned TOL     = 500000,
  parameter int unsigned CNT_W   = 26
) (
  input  logic             clk_fiftymhz,
  input  logic             rst,
  input  logic             clk_onehz,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             stuck,
  output logic             fast_err,
  output logic             slow_err
);

  localparam logic [CNT_W-1:0] C_MIN_P = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] C_MAX_P = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] C_SAT   = CNT_W'(NOMINAL + TOL + 1);
  localparam logic [CNT_W-1:0] C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOST  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_timeout;
  logic             w_capture;
  logic             w_enter_lost;

  // Three-flop chain: s1/s2 resynchronise, s3 is the history for edge detect.
  always_ff @(posedge clk_fiftymhz or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= clk_onehz;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_timeout = (r_cnt == C_MAX_P) && !w_rise;

  always_ff @(posedge clk_fiftymhz or negedge rst) begin
    if (!rst) begin
      r_cnt <= C_ONE;
    end else if (w_rise) begin
      r_cnt <= C_ONE;
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  always_ff @(posedge clk_fiftymhz or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_ARM;
        end else if (w_timeout) begin
          w_state_nxt = ST_LOST;
        end
      end
      ST_ARM, ST_TRACK: begin
        if (w_rise) begin
          w_state_nxt = ST_TRACK;
          w_capture   = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ST_LOST;
        end
      end
      ST_LOST: begin
        // The partial period seen while lost is meaningless, so just re-arm.
        if (w_rise) begin
          w_state_nxt = ST_ARM;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_lost = (w_state_nxt == ST_LOST) && (r_state != ST_LOST);

  always_ff @(posedge clk_fiftymhz or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      fast_err     <= 1'b0;
      slow_err     <= 1'b0;
    end else begin
      period_valid <= w_capture;
      if (w_capture) begin
        period   <= r_cnt;
        in_range <= (r_cnt >= C_MIN_P);
      end else if (w_enter_lost) begin
        in_range <= 1'b0;
      end
      // A set in the same cycle as clr_flags takes priority.
      if (w_capture && (r_cnt < C_MIN_P)) begin
        fast_err <= 1'b1;
      end else if (clr_flags) begin
        fast_err <= 1'b0;
      end
      if (w_enter_lost) begin
        slow_err <= 1'b1;
      end else if (clr_flags) begin
        slow_err <= 1'b0;
      end
    end
  end

  assign locked = (r_state == ST_TRACK) && in_range;
  assign stuck  = (r_state == ST_LOST);

endmodule
`default_nettype wire

// File: tb/tb_onehz_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehz_period_monitor
// Brief    : Directed bench for onehz_period_monitor (MIN_P=95, MAX_P=105).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehz_period_monitor;

  logic       clk_fiftymhz = 1'b0;
  logic       rst;
  logic       clk_onehz;
  logic       clr_flags;
  logic [7:0] period;
  logic       period_valid;
  logic       in_range;
  logic       locked;
  logic       stuck;
  logic       fast_err;
  logic       slow_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_valid  = 0;
  logic [7:0] last_period;
  logic       saw_stuck;

  always #5 clk_fiftymhz = ~clk_fiftymhz;

  onehz_period_monitor #(
    .NOMINAL (100),
    .TOL     (5),
    .CNT_W   (8)
  ) u_dut (
    .clk_fiftymhz (clk_fiftymhz),
    .rst          (rst),
    .clk_onehz    (clk_onehz),
    .clr_flags    (clr_flags),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .locked       (locked),
    .stuck        (stuck),
    .fast_err     (fast_err),
    .slow_err     (slow_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_period"},   32'(period),       0);
    check_eq({tag, "_valid"},    32'(period_valid), 0);
    check_eq({tag, "_in_range"}, 32'(in_range),     0);
    check_eq({tag, "_locked"},   32'(locked),       0);
    check_eq({tag, "_stuck"},    32'(stuck),        0);
    check_eq({tag, "_fast"},     32'(fast_err),     0);
    check_eq({tag, "_slow"},     32'(slow_err),     0);
  endtask

  task automatic sample();
    if (period_valid) begin
      n_valid++;
      last_period = period;
    end
    if (stuck) saw_stuck = 1'b1;
  endtask

  // One slow-clock period of p fast cycles, rising at its first cycle;
  // clr_flags is pulsed on drive index clr_at (-1 for none).
  task automatic run_period(input int p, input int clr_at);
    for (int i = 0; i < p; i++) begin
      @(negedge clk_fiftymhz);
      sample();
      clk_onehz = (i < p / 2);
      clr_flags = (i == clr_at);
    end
    clr_flags = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    clk_onehz   = 1'b0;
    clr_flags   = 1'b0;
    last_period = '0;
    saw_stuck   = 1'b0;
    repeat (3) @(negedge clk_fiftymhz);
    check_zero("reset");
    rst = 1'b1;

    // Nominal 100-cycle wave
    run_period(100, -1);
    check_eq("s1_no_capture_first_rise", n_valid, 0);
    check_eq("s1_unlocked_first_rise", 32'(locked), 0);
    run_period(100, -1);
    check_eq("s1_first_capture", n_valid, 1);
    check_eq("s1_period", 32'(last_period), 100);
    check_eq("s1_in_range", 32'(in_range), 1);
    check_eq("s1_locked_second_rise", 32'(locked), 1);
    run_period(100, -1);
    run_period(100, -1);
    check_eq("s1_captures", n_valid, 3);
    check_eq("s1_period_again", 32'(last_period), 100);
    check_eq("s1_fast", 32'(fast_err), 0);
    check_eq("s1_slow", 32'(slow_err), 0);
    check_eq("s1_stuck", 32'(stuck), 0);

    // Too-fast period of 90
    run_period(90, -1);
    run_period(100, -1);
    check_eq("s2_captures", n_valid, 5);
    check_eq("s2_period", 32'(last_period), 90);
    check_eq("s2_in_range", 32'(in_range), 0);
    check_eq("s2_fast", 32'(fast_err), 1);
    check_eq("s2_locked", 32'(locked), 0);
    run_period(100, -1);
    check_eq("s2_relock_in_track", 32'(locked), 1);

    // Boundary: 105 accepted, 106 times out
    run_period(105, -1);
    run_period(105, -1);
    check_eq("s3_period_max", 32'(last_period), 105);
    check_eq("s3_in_range_max", 32'(in_range), 1);
    check_eq("s3_slow_max", 32'(slow_err), 0);
    run_period(106, -1);
    check_eq("s3_captures", n_valid, 9);
    saw_stuck = 1'b0;
    run_period(100, -1);
    check_eq("s3_no_capture_timeout", n_valid, 9);
    check_eq("s3_saw_stuck", 32'(saw_stuck), 1);
    check_eq("s3_slow", 32'(slow_err), 1);
    check_eq("s3_stuck_cleared", 32'(stuck), 0);
    check_eq("s3_locked", 32'(locked), 0);
    check_eq("s3_in_range_cleared", 32'(in_range), 0);
    check_eq("s3_period_held", 32'(period), 105);

    // clr_flags alone, then colliding with a fast capture
    run_period(100, 50);
    check_eq("s5_clr_fast", 32'(fast_err), 0);
    check_eq("s5_clr_slow", 32'(slow_err), 0);
    check_eq("s5_locked", 32'(locked), 1);
    run_period(90, -1);
    run_period(100, 2);
    check_eq("s5_period", 32'(last_period), 90);
    check_eq("s5_set_wins", 32'(fast_err), 1);
    check_eq("s5_slow", 32'(slow_err), 0);

    // Asynchronous reset mid-period while locked
    run_period(100, -1);
    check_eq("s6_pre_locked", 32'(locked), 1);
    @(negedge clk_fiftymhz);
    clk_onehz = 1'b1;
    repeat (20) @(negedge clk_fiftymhz);
    #1 rst = 1'b0;
    #1 check_zero("s6_async");
    clk_onehz = 1'b0;
    @(negedge clk_fiftymhz);
    rst = 1'b1;

    // Held low after reset: timeout exactly at cnt==105
    repeat (104) @(negedge clk_fiftymhz);
    check_eq("s4_not_stuck_yet", 32'(stuck), 0);
    check_eq("s4_slow_not_yet", 32'(slow_err), 0);
    @(negedge clk_fiftymhz);
    check_eq("s4_stuck", 32'(stuck), 1);
    check_eq("s4_slow", 32'(slow_err), 1);
    check_eq("s4_period_reset", 32'(period), 0);
    n_valid = 0;
    run_period(100, -1);
    check_eq("s4_stuck_clear_rise1", 32'(stuck), 0);
    check_eq("s4_no_capture_rise1", n_valid, 0);
    run_period(100, -1);
    check_eq("s4_capture_rise2", n_valid, 1);
    check_eq("s4_period", 32'(last_period), 100);
    run_period(100, -1);
    check_eq("s4_locked_rise3", 32'(locked), 1);
    check_eq("s4_captures", n_valid, 2);
    check_eq("s4_fast", 32'(fast_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
